// File: rtl/sram_axi_pkg.sv
// rtl/sram_axi_pkg.sv - shared AXI constants, write-buffer states and index helper for sram_axi_bridge
package sram_axi_pkg;

   localparam logic [7:0] LEN_SINGLE = 8'd0;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] LOCK_NONE  = 2'b00;
   localparam logic [3:0] CACHE_NONE = 4'b0000;
   localparam logic [2:0] PROT_NONE  = 3'b000;

   typedef enum logic [1:0] {
      WR_IDLE      = 2'd0,
      WR_ADDR_DATA = 2'd1,
      WR_RESP      = 2'd2
   } wr_state_e;

   // Channel-index width; a single channel still needs one bit to hold index 0.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/bridge_ch_resp.sv
// rtl/bridge_ch_resp.sv - per-channel outstanding flag and registered completion/read-data
module bridge_ch_resp (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_accept,
   input  logic        i_r_hit,
   input  logic        i_b_hit,
   input  logic [31:0] i_rdata,
   output logic        o_busy,
   output logic        o_data_ok,
   output logic [31:0] o_rdata
);

   logic        r_busy;
   logic        r_data_ok;
   logic [31:0] r_rdata;
   logic        w_done;

   // Responses for a channel with nothing outstanding (e.g. stale after reset) are dropped.
   assign w_done = r_busy & ~r_data_ok & (i_r_hit | i_b_hit);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_data_ok <= 1'b0;
         r_rdata   <= 32'd0;
      end else begin
         r_data_ok <= w_done;
         if (i_accept)
            r_busy <= 1'b1;
         else if (r_data_ok)
            r_busy <= 1'b0;
         if (w_done & i_r_hit)
            r_rdata <= i_rdata;
      end
   end

   assign o_busy    = r_busy;
   assign o_data_ok = r_data_ok;
   assign o_rdata   = r_rdata;

endmodule

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - NUM_CH SRAM-like master channels onto one single-beat AXI3 master
module sram_axi_bridge
   import sram_axi_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ID_W   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      s_req,
   input  logic [NUM_CH-1:0]      s_wr,
   input  logic [2*NUM_CH-1:0]    s_size,
   input  logic [4*NUM_CH-1:0]    s_wstrb,
   input  logic [32*NUM_CH-1:0]   s_addr,
   input  logic [32*NUM_CH-1:0]   s_wdata,
   output logic [NUM_CH-1:0]      s_addr_ok,
   output logic [NUM_CH-1:0]      s_data_ok,
   output logic [32*NUM_CH-1:0]   s_rdata,
   output logic [ID_W-1:0]        arid,
   output logic [31:0]            araddr,
   output logic [7:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   output logic [1:0]             arlock,
   output logic [3:0]             arcache,
   output logic [2:0]             arprot,
   output logic                   arvalid,
   input  logic                   arready,
   input  logic [ID_W-1:0]        rid,
   input  logic [31:0]            rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   input  logic                   rvalid,
   output logic                   rready,
   output logic [ID_W-1:0]        awid,
   output logic [31:0]            awaddr,
   output logic [7:0]             awlen,
   output logic [2:0]             awsize,
   output logic [1:0]             awburst,
   output logic [1:0]             awlock,
   output logic [3:0]             awcache,
   output logic [2:0]             awprot,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [ID_W-1:0]        wid,
   output logic [31:0]            wdata,
   output logic [3:0]             wstrb,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   input  logic [ID_W-1:0]        bid,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready
);

   localparam int CH_IDX_W = ch_idx_w(NUM_CH);

   logic                r_axi_ready;
   logic                r_ar_valid;
   logic [31:0]         r_ar_addr;
   logic [1:0]          r_ar_size;
   logic [CH_IDX_W-1:0] r_ar_id;
   wr_state_e           r_wr_state;
   logic                r_aw_valid;
   logic                r_w_valid;
   logic [31:0]         r_wr_addr;
   logic [31:0]         r_wr_data;
   logic [3:0]          r_wr_strb;
   logic [1:0]          r_wr_size;
   logic [CH_IDX_W-1:0] r_wr_owner;

   logic [NUM_CH-1:0]   w_busy;
   logic [NUM_CH-1:0]   w_eligible;
   logic [NUM_CH-1:0]   w_grant;
   logic [NUM_CH-1:0]   w_r_hit;
   logic [NUM_CH-1:0]   w_b_hit;
   logic                w_grant_any;
   logic                w_grant_wr;
   logic [CH_IDX_W-1:0] w_grant_idx;
   logic [31:0]         w_sel_addr;
   logic [31:0]         w_sel_data;
   logic [3:0]          w_sel_strb;
   logic [1:0]          w_sel_size;
   logic                w_unused;

   // busy stays high through the data_ok cycle, so a completing channel waits one more cycle.
   always_comb begin
      w_eligible = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (s_req[c] & ~w_busy[c] & ~reset) begin
            if (s_wr[c])
               w_eligible[c] = (r_wr_state == WR_IDLE);
            else
               w_eligible[c] = ~r_ar_valid &
                               ~((r_wr_state != WR_IDLE) && (r_wr_addr[31:2] == s_addr[c*32+2 +: 30]));
         end
      end
   end

   always_comb begin
      w_grant     = '0;
      w_grant_any = 1'b0;
      w_grant_wr  = 1'b0;
      w_grant_idx = '0;
      w_sel_addr  = 32'd0;
      w_sel_data  = 32'd0;
      w_sel_strb  = 4'd0;
      w_sel_size  = 2'd0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_eligible[c]) begin
            w_grant     = '0;
            w_grant[c]  = 1'b1;
            w_grant_any = 1'b1;
            w_grant_wr  = s_wr[c];
            w_grant_idx = CH_IDX_W'(c);
            w_sel_addr  = s_addr[c*32 +: 32];
            w_sel_data  = s_wdata[c*32 +: 32];
            w_sel_strb  = s_wstrb[c*4 +: 4];
            w_sel_size  = s_size[c*2 +: 2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_axi_ready <= 1'b0;
         r_ar_valid  <= 1'b0;
         r_ar_addr   <= 32'd0;
         r_ar_size   <= 2'd0;
         r_ar_id     <= '0;
         r_wr_state  <= WR_IDLE;
         r_aw_valid  <= 1'b0;
         r_w_valid   <= 1'b0;
         r_wr_addr   <= 32'd0;
         r_wr_data   <= 32'd0;
         r_wr_strb   <= 4'd0;
         r_wr_size   <= 2'd0;
         r_wr_owner  <= '0;
      end else begin
         r_axi_ready <= 1'b1;
         if (r_ar_valid & arready)
            r_ar_valid <= 1'b0;
         if (w_grant_any & ~w_grant_wr) begin
            r_ar_valid <= 1'b1;
            r_ar_addr  <= w_sel_addr;
            r_ar_size  <= w_sel_size;
            r_ar_id    <= w_grant_idx;
         end
         case (r_wr_state)
            WR_IDLE: begin
               if (w_grant_any & w_grant_wr) begin
                  r_wr_state <= WR_ADDR_DATA;
                  r_aw_valid <= 1'b1;
                  r_w_valid  <= 1'b1;
                  r_wr_addr  <= w_sel_addr;
                  r_wr_data  <= w_sel_data;
                  r_wr_strb  <= w_sel_strb;
                  r_wr_size  <= w_sel_size;
                  r_wr_owner <= w_grant_idx;
               end
            end
            WR_ADDR_DATA: begin
               if (awready) r_aw_valid <= 1'b0;
               if (wready)  r_w_valid  <= 1'b0;
               if ((~r_aw_valid | awready) & (~r_w_valid | wready))
                  r_wr_state <= WR_RESP;
            end
            WR_RESP: begin
               if (bvalid & r_axi_ready)
                  r_wr_state <= WR_IDLE;
            end
            default: r_wr_state <= WR_IDLE;
         endcase
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         assign w_r_hit[g] = rvalid & r_axi_ready & (rid == ID_W'(g));
         assign w_b_hit[g] = bvalid & r_axi_ready & (r_wr_state == WR_RESP) &
                             (r_wr_owner == CH_IDX_W'(g));
         bridge_ch_resp u_resp (
            .clk       (clk),
            .reset     (reset),
            .i_accept  (w_grant[g]),
            .i_r_hit   (w_r_hit[g]),
            .i_b_hit   (w_b_hit[g]),
            .i_rdata   (rdata),
            .o_busy    (w_busy[g]),
            .o_data_ok (s_data_ok[g]),
            .o_rdata   (s_rdata[g*32 +: 32])
         );
      end
   endgenerate

   assign w_unused  = ^{rresp, rlast, bid, bresp};

   assign s_addr_ok = w_grant;
   assign rready    = r_axi_ready;
   assign bready    = r_axi_ready;

   assign arid    = ID_W'(r_ar_id);
   assign araddr  = r_ar_addr;
   assign arlen   = LEN_SINGLE;
   assign arsize  = {1'b0, r_ar_size};
   assign arburst = BURST_INCR;
   assign arlock  = LOCK_NONE;
   assign arcache = CACHE_NONE;
   assign arprot  = PROT_NONE;
   assign arvalid = r_ar_valid;

   assign awid    = ID_W'(r_wr_owner);
   assign awaddr  = r_wr_addr;
   assign awlen   = LEN_SINGLE;
   assign awsize  = {1'b0, r_wr_size};
   assign awburst = BURST_INCR;
   assign awlock  = LOCK_NONE;
   assign awcache = CACHE_NONE;
   assign awprot  = PROT_NONE;
   assign awvalid = r_aw_valid;

   assign wid     = ID_W'(r_wr_owner);
   assign wdata   = r_wr_data;
   assign wstrb   = r_wr_strb;
   assign wlast   = 1'b1;
   assign wvalid  = r_w_valid;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - directed bench for sram_axi_bridge with a hand-driven AXI slave
module tb_sram_axi_bridge;

   logic        clk;
   logic        reset;
   logic [1:0]  s_req, s_wr, s_addr_ok, s_data_ok;
   logic [3:0]  s_size;
   logic [7:0]  s_wstrb;
   logic [63:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  arid, rid, awid, wid, bid;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int n_checks = 0;
   int n_fail   = 0;

   sram_axi_bridge #(.NUM_CH(2), .ID_W(4)) dut (
      .clk(clk), .reset(reset),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
      .s_addr(s_addr), .s_wdata(s_wdata),
      .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task clear_inputs;
      s_req = 0; s_wr = 0; s_size = 0; s_wstrb = 0; s_addr = 0; s_wdata = 0;
      arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
      awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
   endtask

   task set_rd(input int c, input logic [31:0] a, input logic [1:0] sz);
      s_req[c] = 1'b1; s_wr[c] = 1'b0;
      s_addr[c*32 +: 32] = a; s_size[c*2 +: 2] = sz;
   endtask

   task set_wr(input int c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
      s_req[c] = 1'b1; s_wr[c] = 1'b1;
      s_addr[c*32 +: 32] = a; s_wdata[c*32 +: 32] = d;
      s_wstrb[c*4 +: 4] = st; s_size[c*2 +: 2] = 2'd2;
   endtask

   // One posedge with reset high, then the next test starts after one clean posedge.
   task apply_reset;
      @(negedge clk); reset = 1'b1; clear_inputs;
      @(negedge clk); reset = 1'b0;
   endtask

   task test_reset;
      reset = 1'b1; clear_inputs;
      repeat (2) @(negedge clk);
      set_rd(0, 32'h10, 2'd2); #1;
      n_checks++; if (s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL rst_addr_ok: got %b want 00", s_addr_ok); end
      n_checks++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b want 000", {arvalid, awvalid, wvalid}); end
      n_checks++; if (s_data_ok !== 2'b00 || s_rdata !== 64'd0) begin n_fail++; $display("FAIL rst_resp: got %b/%h want 00/0", s_data_ok, s_rdata); end
      n_checks++; if ({rready, bready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {rready, bready}); end
      @(negedge clk); s_req = 0; reset = 1'b0;
      @(negedge clk); #1;
      n_checks++; if ({rready, bready} !== 2'b11) begin n_fail++; $display("FAIL post_rst_ready: got %b want 11", {rready, bready}); end
      n_checks++; if ({arlen, arburst, awlen, awburst} !== {8'd0, 2'b01, 8'd0, 2'b01}) begin n_fail++; $display("FAIL axi_consts: got %h", {arlen, arburst, awlen, awburst}); end
      n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_arvalid: got %b want 0", arvalid); end
   endtask

   task test_single_read;
      apply_reset;
      @(negedge clk); set_rd(0, 32'h1c000000, 2'd2); #1;
      n_checks++; if (s_addr_ok !== 2'b01 || arvalid !== 1'b0) begin n_fail++; $display("FAIL rd1_accept: got ok=%b arvalid=%b want 01/0", s_addr_ok, arvalid); end
      @(negedge clk); s_req = 0; arready = 1'b1; #1;
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h1c000000 || arid !== 4'd0 || arsize !== 3'b010) begin n_fail++; $display("FAIL rd1_ar: got v=%b a=%h id=%h sz=%b", arvalid, araddr, arid, arsize); end
      @(negedge clk); arready = 1'b0; #1;
      n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rd1_ar_drop: got %b want 0", arvalid); end
      @(negedge clk);
      @(negedge clk); rvalid = 1'b1; rid = 4'd0; rdata = 32'hdeadbeef; #1;
      n_checks++; if (s_data_ok !== 2'b00) begin n_fail++; $display("FAIL rd1_early_ok: got %b want 00", s_data_ok); end
      @(negedge clk); rvalid = 1'b0; #1;
      n_checks++; if (s_data_ok !== 2'b01 || s_rdata[31:0] !== 32'hdeadbeef) begin n_fail++; $display("FAIL rd1_data: got %b/%h want 01/deadbeef", s_data_ok, s_rdata[31:0]); end
      @(negedge clk); #1;
      n_checks++; if (s_data_ok !== 2'b00) begin n_fail++; $display("FAIL rd1_pulse: got %b want 00", s_data_ok); end
   endtask

   task test_priority;
      apply_reset;
      @(negedge clk); set_rd(0, 32'h1000, 2'd2); set_rd(1, 32'h2000, 2'd2); #1;
      n_checks++; if (s_addr_ok !== 2'b10) begin n_fail++; $display("FAIL prio_first: got %b want 10", s_addr_ok); end
      @(negedge clk); s_req[1] = 1'b0; arready = 1'b1; #1;
      n_checks++; if (s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL prio_ar_full: got %b want 00", s_addr_ok); end
      n_checks++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h2000) begin n_fail++; $display("FAIL prio_ar1: got v=%b id=%h a=%h", arvalid, arid, araddr); end
      @(negedge clk); arready = 1'b0; #1;
      n_checks++; if (s_addr_ok !== 2'b01) begin n_fail++; $display("FAIL prio_second: got %b want 01", s_addr_ok); end
      @(negedge clk); s_req = 0; arready = 1'b1; #1;
      n_checks++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1000) begin n_fail++; $display("FAIL prio_ar0: got v=%b id=%h a=%h", arvalid, arid, araddr); end
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h22222222;
      @(negedge clk); rid = 4'd1; rdata = 32'h11111111; #1;
      n_checks++; if (s_data_ok !== 2'b01 || s_rdata[31:0] !== 32'h22222222) begin n_fail++; $display("FAIL prio_r0: got %b/%h", s_data_ok, s_rdata[31:0]); end
      @(negedge clk); rvalid = 1'b0; #1;
      n_checks++; if (s_data_ok !== 2'b10 || s_rdata[63:32] !== 32'h11111111) begin n_fail++; $display("FAIL prio_r1: got %b/%h", s_data_ok, s_rdata[63:32]); end
   endtask

   task test_raw_same_channel;
      apply_reset;
      @(negedge clk); set_wr(1, 32'h100, 32'hcafef00d, 4'hf); #1;
      n_checks++; if (s_addr_ok !== 2'b10) begin n_fail++; $display("FAIL raw_wr_accept: got %b want 10", s_addr_ok); end
      @(negedge clk); set_rd(1, 32'h100, 2'd2); wready = 1'b1; #1;
      n_checks++; if (s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_hold1: got %b want 00", s_addr_ok); end
      n_checks++; if ({awvalid, wvalid, wlast} !== 3'b111 || awaddr !== 32'h100 || awid !== 4'd1 || wid !== 4'd1) begin n_fail++; $display("FAIL raw_aw_w: got %b a=%h id=%h/%h", {awvalid, wvalid, wlast}, awaddr, awid, wid); end
      n_checks++; if (wdata !== 32'hcafef00d || wstrb !== 4'hf || awsize !== 3'b010) begin n_fail++; $display("FAIL raw_wfields: got %h/%h/%b", wdata, wstrb, awsize); end
      @(negedge clk); wready = 1'b0; #1;
      n_checks++; if ({awvalid, wvalid} !== 2'b10 || s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_w_done: got %b ok=%b want 10/00", {awvalid, wvalid}, s_addr_ok); end
      @(negedge clk); awready = 1'b1; #1;
      n_checks++; if (awvalid !== 1'b1 || s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_aw_wait: got %b ok=%b", awvalid, s_addr_ok); end
      @(negedge clk); awready = 1'b0; bvalid = 1'b1; bid = 4'd1; #1;
      n_checks++; if (awvalid !== 1'b0 || s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_resp_wait: got %b ok=%b", awvalid, s_addr_ok); end
      @(negedge clk); bvalid = 1'b0; #1;
      n_checks++; if (s_data_ok !== 2'b10 || s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_bpulse: got dok=%b ok=%b want 10/00", s_data_ok, s_addr_ok); end
      @(negedge clk); #1;
      n_checks++; if (s_data_ok !== 2'b00 || s_addr_ok !== 2'b10) begin n_fail++; $display("FAIL raw_release: got dok=%b ok=%b want 00/10", s_data_ok, s_addr_ok); end
      @(negedge clk); s_req = 0; #1;
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h100 || arid !== 4'd1) begin n_fail++; $display("FAIL raw_ar: got v=%b a=%h id=%h", arvalid, araddr, arid); end
   endtask

   task test_raw_other_channel;
      apply_reset;
      @(negedge clk); set_wr(1, 32'h104, 32'h0badf00d, 4'h3);
      @(negedge clk); s_req[1] = 1'b0; set_rd(0, 32'h106, 2'd0); awready = 1'b1; wready = 1'b1; #1;
      n_checks++; if (s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL haz_block1: got %b want 00", s_addr_ok); end
      @(negedge clk); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd1; #1;
      n_checks++; if (s_addr_ok !== 2'b00) begin n_fail++; $display("FAIL haz_block2: got %b want 00", s_addr_ok); end
      @(negedge clk); bvalid = 1'b0; #1;
      n_checks++; if (s_data_ok !== 2'b10 || s_addr_ok !== 2'b01) begin n_fail++; $display("FAIL haz_release: got dok=%b ok=%b want 10/01", s_data_ok, s_addr_ok); end
      @(negedge clk); s_req = 0; #1;
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h106 || arsize !== 3'b000 || arid !== 4'd0) begin n_fail++; $display("FAIL haz_ar: got v=%b a=%h sz=%b id=%h", arvalid, araddr, arsize, arid); end
   endtask

   task test_out_of_order;
      apply_reset;
      @(negedge clk); set_rd(0, 32'ha0, 2'd2);
      @(negedge clk); s_req = 0; arready = 1'b1;
      @(negedge clk); set_rd(1, 32'hb0, 2'd1); #1;
      n_checks++; if (s_addr_ok !== 2'b10) begin n_fail++; $display("FAIL ooo_accept1: got %b want 10", s_addr_ok); end
      @(negedge clk); s_req = 0; #1;
      n_checks++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'hb0 || arsize !== 3'b001) begin n_fail++; $display("FAIL ooo_ar1: got v=%b id=%h a=%h sz=%b", arvalid, arid, araddr, arsize); end
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'hbbbb0001;
      @(negedge clk); rid = 4'd0; rdata = 32'haaaa0000; #1;
      n_checks++; if (s_data_ok !== 2'b10 || s_rdata[63:32] !== 32'hbbbb0001) begin n_fail++; $display("FAIL ooo_r1: got %b/%h", s_data_ok, s_rdata[63:32]); end
      @(negedge clk); rvalid = 1'b0; #1;
      n_checks++; if (s_data_ok !== 2'b01 || s_rdata !== 64'hbbbb0001_aaaa0000) begin n_fail++; $display("FAIL ooo_r0: got %b/%h", s_data_ok, s_rdata); end
   endtask

   task test_concurrent_r_b;
      apply_reset;
      @(negedge clk); set_wr(1, 32'h300, 32'h12345678, 4'hc); set_rd(0, 32'h200, 2'd2); #1;
      n_checks++; if (s_addr_ok !== 2'b10) begin n_fail++; $display("FAIL rb_first: got %b want 10", s_addr_ok); end
      @(negedge clk); s_req[1] = 1'b0; awready = 1'b1; wready = 1'b1; #1;
      n_checks++; if (s_addr_ok !== 2'b01 || {awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL rb_no_hazard: got ok=%b aw/w=%b", s_addr_ok, {awvalid, wvalid}); end
      @(negedge clk); s_req = 0; awready = 1'b0; wready = 1'b0; arready = 1'b1; #1;
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h200 || {awvalid, wvalid} !== 2'b00) begin n_fail++; $display("FAIL rb_ar: got v=%b a=%h aw/w=%b", arvalid, araddr, {awvalid, wvalid}); end
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h5a5a5a5a; bvalid = 1'b1; bid = 4'd1;
      @(negedge clk); rvalid = 1'b0; bvalid = 1'b0; #1;
      n_checks++; if (s_data_ok !== 2'b11 || s_rdata[31:0] !== 32'h5a5a5a5a) begin n_fail++; $display("FAIL rb_both: got %b/%h want 11/5a5a5a5a", s_data_ok, s_rdata[31:0]); end
   endtask

   task test_reset_mid;
      apply_reset;
      @(negedge clk); set_rd(0, 32'h400, 2'd2);
      @(negedge clk); s_req = 0; #1;
      n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL rm_arvalid: got %b want 1", arvalid); end
      reset = 1'b1;
      @(negedge clk); reset = 1'b0; set_rd(0, 32'h500, 2'd2); #1;
      n_checks++; if (arvalid !== 1'b0 || s_data_ok !== 2'b00) begin n_fail++; $display("FAIL rm_cleared: got v=%b dok=%b", arvalid, s_data_ok); end
      n_checks++; if (s_addr_ok !== 2'b01) begin n_fail++; $display("FAIL rm_fresh_accept: got %b want 01", s_addr_ok); end
      @(negedge clk); s_req = 0; #1;
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h500) begin n_fail++; $display("FAIL rm_ar: got v=%b a=%h", arvalid, araddr); end
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_priority;
      test_raw_same_channel;
      test_raw_other_channel;
      test_out_of_order;
      test_concurrent_r_b;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
